// File: rtl/spi_slave.sv
// SPI slave: SCK/SS/MOSI resynchronized into c_clk_100m, MSB-first frames of TRAN_WIDTH bits.
// Define SPI_SLAVE_FRAME_ERR_EN to add o_SPI_Frame_Err (pulses on frames cut short by SS).
module spi_slave #(
   parameter logic IDLE_VALUE_for_Clk    = 1'b0,
   parameter logic DATA_VALID_at_FALLING = 1'b0,
   parameter int   TRAN_WIDTH            = 8,
   parameter logic IDLE_VALUE_for_MISO   = 1'b0
) (
   input  logic                  c_clk_100m,
   input  logic                  i_rst_n,
   input  logic                  i_SPI_Clk,
   input  logic                  i_SPI_SS,
   input  logic                  i_SPI_MOSI,
   output logic                  o_SPI_MISO,
   input  logic                  i_SPI_Send_Sync,
   input  logic [TRAN_WIDTH-1:0] i_SPI_Send_Data,
   output logic                  o_SPI_Send_Over_ack,
   output logic                  o_SPI_Receive_Sync,
   output logic [TRAN_WIDTH-1:0] o_SPI_Receive_Data
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,
   output logic                  o_SPI_Frame_Err
`endif
);
   localparam int CW = $clog2(TRAN_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(TRAN_WIDTH - 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t                state_q;
   logic [2:0]            sck_q, ss_q;
   logic [1:0]            mosi_q;
   logic [CW-1:0]         cnt_q;
   logic [TRAN_WIDTH-1:0] hold_q, tx_q, rdata_q;
   logic [TRAN_WIDTH-2:0] rx_q;
   logic [TRAN_WIDTH-1:0] rx_d;
   logic                  pend_q, carry_q, wr_q, rsync_q, ack_q;
   logic                  sck_rise, sck_fall, ss_rise, ss_fall;
   logic                  active, samp_e, shift_e, reload_pend;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic                  ferr_q;
`endif

   // [0],[1] are the synchronizer; [2] holds the previous synchronized level for edge detect
   always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sck_q  <= {3{IDLE_VALUE_for_Clk}};
         ss_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], i_SPI_Clk};
         ss_q   <= {ss_q[1:0], i_SPI_SS};
         mosi_q <= {mosi_q[0], i_SPI_MOSI};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign ss_rise  = ss_q[1] & ~ss_q[2];
   assign ss_fall  = ~ss_q[1] & ss_q[2];

   assign active  = (state_q == ST_SHIFT) && !ss_rise;
   assign samp_e  = active && (DATA_VALID_at_FALLING ? sck_fall : sck_rise);
   // counter==0 means no sample edge yet in this frame, so the leading shift edge is dropped
   assign shift_e = active && (DATA_VALID_at_FALLING ? sck_rise : sck_fall) && (cnt_q != '0);
   assign rx_d    = {rx_q, mosi_q[1]};
   // pending as it stands once the current frame completes (consumed unless rewritten mid-frame)
   assign reload_pend = pend_q && !(carry_q && !wr_q);

   always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         pend_q  <= 1'b0;
         carry_q <= 1'b0;
         wr_q    <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         rsync_q <= 1'b0;
         ack_q   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         ferr_q  <= 1'b0;
`endif
      end else begin
         rsync_q <= 1'b0;
         ack_q   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         ferr_q  <= 1'b0;
`endif
         if (i_SPI_Send_Sync) begin
            hold_q <= i_SPI_Send_Data;
            pend_q <= 1'b1;
            wr_q   <= 1'b1;
         end
         if (ss_rise) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            ferr_q  <= (state_q == ST_SHIFT) && (cnt_q != '0);
`endif
         end else if (state_q == ST_IDLE) begin
            if (ss_fall) begin
               state_q <= ST_SHIFT;
               cnt_q   <= '0;
               tx_q    <= pend_q ? hold_q : '0;
               carry_q <= pend_q;
               wr_q    <= i_SPI_Send_Sync;
            end
         end else if (samp_e) begin
            rx_q <= rx_d[TRAN_WIDTH-2:0];
            if (cnt_q == LAST) begin
               cnt_q   <= '0;
               rdata_q <= rx_d;
               rsync_q <= 1'b1;
               ack_q   <= carry_q;
               if (carry_q && !wr_q && !i_SPI_Send_Sync)
                  pend_q <= 1'b0;
               tx_q    <= reload_pend ? hold_q : '0;
               carry_q <= reload_pend;
               wr_q    <= i_SPI_Send_Sync;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else if (shift_e) begin
            tx_q <= {tx_q[TRAN_WIDTH-2:0], 1'b0};
         end
      end
   end

   assign o_SPI_MISO          = (state_q == ST_SHIFT) ? tx_q[TRAN_WIDTH-1] : IDLE_VALUE_for_MISO;
   assign o_SPI_Receive_Data  = rdata_q;
   assign o_SPI_Receive_Sync  = rsync_q;
   assign o_SPI_Send_Over_ack = ack_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   assign o_SPI_Frame_Err     = ferr_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an 8-bit mode-0 instance and a 24-bit CPOL=1/falling-sample instance
// driven by a bit-level master, checked against a word-level model of holding/pending behaviour.
module tb_spi_slave;
   localparam int WA = 8;
   localparam int WB = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic sck_a = 1'b0, ss_a = 1'b1, sck_b = 1'b1, ss_b = 1'b1, mosi = 1'b0;
   logic ssync_a = 1'b0, ssync_b = 1'b0;
   logic [WA-1:0] sdata_a = '0;
   logic [WB-1:0] sdata_b = '0;
   logic miso_a, miso_b, ack_a, ack_b, rs_a, rs_b;
   logic [WA-1:0] rd_a;
   logic [WB-1:0] rd_b;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic fe_a, fe_b;
`endif

   spi_slave u_a (
      .c_clk_100m(clk), .i_rst_n(rst_n), .i_SPI_Clk(sck_a), .i_SPI_SS(ss_a), .i_SPI_MOSI(mosi),
      .o_SPI_MISO(miso_a), .i_SPI_Send_Sync(ssync_a), .i_SPI_Send_Data(sdata_a),
      .o_SPI_Send_Over_ack(ack_a), .o_SPI_Receive_Sync(rs_a), .o_SPI_Receive_Data(rd_a)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      , .o_SPI_Frame_Err(fe_a)
`endif
   );

   spi_slave #(.IDLE_VALUE_for_Clk(1'b1), .DATA_VALID_at_FALLING(1'b1), .TRAN_WIDTH(WB),
               .IDLE_VALUE_for_MISO(1'b1)) u_b (
      .c_clk_100m(clk), .i_rst_n(rst_n), .i_SPI_Clk(sck_b), .i_SPI_SS(ss_b), .i_SPI_MOSI(mosi),
      .o_SPI_MISO(miso_b), .i_SPI_Send_Sync(ssync_b), .i_SPI_Send_Data(sdata_b),
      .o_SPI_Send_Over_ack(ack_b), .o_SPI_Receive_Sync(rs_b), .o_SPI_Receive_Data(rd_b)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      , .o_SPI_Frame_Err(fe_b)
`endif
   );

   int checks = 0, failures = 0;
   bit started = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // word-level model: holding word, pending flag, write generation at frame load
   typedef struct {logic [31:0] d; bit ack;} ev_t;
   ev_t q_a[$], q_b[$];
   logic [31:0] m_hold[2], m_tx[2], m_rd[2];
   bit m_pend[2], m_carry[2], m_part[2];
   int m_gen[2], m_ldgen[2], m_ferr[2], ferr_seen[2], rs_cnt[2], ack_cnt[2], ssh[2];

   function automatic logic [31:0] wmask(input int sel);
      return sel ? 32'h00FF_FFFF : 32'h0000_00FF;
   endfunction

   function automatic void mdl_start(input int sel);
      m_tx[sel]    = m_pend[sel] ? m_hold[sel] : 32'h0;
      m_carry[sel] = m_pend[sel];
      m_ldgen[sel] = m_gen[sel];
   endfunction

   function automatic void mdl_write(input int sel, input logic [31:0] d);
      m_hold[sel] = d & wmask(sel);
      m_pend[sel] = 1'b1;
      m_gen[sel]++;
   endfunction

   function automatic void mdl_done(input int sel, input logic [31:0] rx);
      ev_t e;
      e.d = rx; e.ack = m_carry[sel];
      if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
      if (m_carry[sel] && m_gen[sel] == m_ldgen[sel]) m_pend[sel] = 1'b0;
      mdl_start(sel);
   endfunction

   function automatic void mdl_reset();
      for (int s = 0; s < 2; s++) begin
         m_hold[s] = '0; m_pend[s] = 0; m_rd[s] = '0; m_part[s] = 0; m_carry[s] = 0;
      end
      q_a.delete(); q_b.delete();
   endfunction

   // compare process: pulses against the expected-event queues, held data, idle MISO
   ev_t ev;
   always @(negedge clk) begin
      if (started) begin
         if (rs_a) begin
            rs_cnt[0]++;
            if (q_a.size() == 0) chk("rx_sync_a_extra", rs_a, 1'b0);
            else begin
               ev = q_a.pop_front();
               chk("rx_data_a", rd_a, ev.d); chk("ack_a", ack_a, ev.ack); m_rd[0] = ev.d;
            end
         end else chk("ack_a_no_rx", ack_a, 1'b0);
         if (rs_b) begin
            rs_cnt[1]++;
            if (q_b.size() == 0) chk("rx_sync_b_extra", rs_b, 1'b0);
            else begin
               ev = q_b.pop_front();
               chk("rx_data_b", rd_b, ev.d); chk("ack_b", ack_b, ev.ack); m_rd[1] = ev.d;
            end
         end else chk("ack_b_no_rx", ack_b, 1'b0);
         if (ack_a) ack_cnt[0]++;
         if (ack_b) ack_cnt[1]++;
         chk("rx_hold_a", rd_a, m_rd[0]);
         chk("rx_hold_b", rd_b, m_rd[1]);
         if (ss_a) ssh[0]++; else ssh[0] = 0;
         if (ss_b) ssh[1]++; else ssh[1] = 0;
         if (ssh[0] >= 4) chk("miso_idle_a", miso_a, 1'b0);
         if (ssh[1] >= 4) chk("miso_idle_b", miso_b, 1'b1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
         if (fe_a) ferr_seen[0]++;
         if (fe_b) ferr_seen[1]++;
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_sck(input int sel, input logic lvl);
      if (sel == 0) sck_a = lvl; else sck_b = ~lvl;
   endtask

   task automatic set_ss(input int sel, input logic lvl);
      if (sel == 0) ss_a = lvl; else ss_b = lvl;
   endtask

   task automatic wr(input int sel, input logic [31:0] d);
      if (sel == 0) begin ssync_a = 1'b1; sdata_a = d[WA-1:0]; end
      else begin ssync_b = 1'b1; sdata_b = d[WB-1:0]; end
      mdl_write(sel, d);
      tick(1);
      ssync_a = 1'b0; ssync_b = 1'b0;
   endtask

   task automatic ss_low(input int sel);
      set_ss(sel, 1'b0);
      mdl_start(sel);
      tick(6);
   endtask

   task automatic ss_high(input int sel);
      tick(5);
      set_ss(sel, 1'b1);
      tick(8);
      if (m_part[sel]) begin m_ferr[sel]++; m_part[sel] = 0; end
      chk("pulse_backlog", sel ? q_b.size() : q_a.size(), 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      chk("frame_err_cnt", ferr_seen[sel], m_ferr[sel]);
`endif
   endtask

   // one word (or nbits of it); sample edge leads, master samples MISO on that edge
   task automatic xfer(input int sel, input int nbits, input logic [31:0] mw, input int wr_bit,
                       input logic [31:0] wv, output logic [31:0] got);
      int w;
      logic [31:0] g;
      w = sel ? WB : WA;
      g = '0;
      for (int i = 0; i < nbits; i++) begin
         if (i == wr_bit) wr(sel, wv);
         mosi = mw[w-1-i];
         tick(5);
         set_sck(sel, 1'b1);
         g = {g[30:0], (sel ? miso_b : miso_a)};
         if (i == w - 1) begin
            chk("miso_word", g, m_tx[sel]);
            mdl_done(sel, mw & wmask(sel));
         end
         tick(5);
         set_sck(sel, 1'b0);
      end
      if (nbits < w) begin
         chk("miso_partial", g, m_tx[sel] >> (w - nbits));
         m_part[sel] = 1'b1;
      end
      got = g;
   endtask

   initial begin
      logic [31:0] got, got2;
      int r0, a0, f0, sel, w, nw, wb, nb;
      mdl_reset();
      tick(1);
      started = 1'b1;
      tick(2);
      chk("reset_rd_a", rd_a, 8'h00);   chk("reset_rd_b", rd_b, 24'h0);
      chk("reset_rs_a", rs_a, 1'b0);    chk("reset_ack_a", ack_a, 1'b0);
      chk("reset_miso_a", miso_a, 1'b0); chk("reset_miso_b", miso_b, 1'b1);
      rst_n = 1'b1;
      tick(4);

      // 8-bit: write A5, master sends 3C
      r0 = rs_cnt[0]; a0 = ack_cnt[0];
      wr(0, 32'hA5); ss_low(0); xfer(0, 8, 32'h3C, -1, 0, got); ss_high(0);
      chk("w8_miso", got, 32'hA5); chk("w8_rd", rd_a, 8'h3C);
      chk("w8_rs_pulses", rs_cnt[0] - r0, 1); chk("w8_ack_pulses", ack_cnt[0] - a0, 1);

      // 24-bit, CPOL=1, falling sample
      wr(1, 32'h80A5A5); ss_low(1); xfer(1, 24, 32'h5A5A01, -1, 0, got); ss_high(1);
      chk("w24_miso", got, 32'h80A5A5); chk("w24_rd", rd_b, 24'h5A5A01);

      // no write -> zeros, no ack
      r0 = rs_cnt[0]; a0 = ack_cnt[0];
      ss_low(0); xfer(0, 8, 32'h7E, -1, 0, got); ss_high(0);
      chk("nowr_miso", got, 32'h0); chk("nowr_rs", rs_cnt[0] - r0, 1);
      chk("nowr_ack", ack_cnt[0] - a0, 0);

      // back-to-back: 0x11 then 0x22 written during the first frame
      r0 = rs_cnt[0]; a0 = ack_cnt[0];
      wr(0, 32'h11); ss_low(0);
      xfer(0, 8, 32'hE1, 3, 32'h22, got); xfer(0, 8, 32'h1E, -1, 0, got2); ss_high(0);
      chk("b2b_first", got, 32'h11); chk("b2b_second", got2, 32'h22);
      chk("b2b_rs", rs_cnt[0] - r0, 2); chk("b2b_ack", ack_cnt[0] - a0, 2);

      // truncated after 5 bits keeps the pending word
      r0 = rs_cnt[0]; a0 = ack_cnt[0]; f0 = ferr_seen[0];
      wr(0, 32'h77); ss_low(0); xfer(0, 5, 32'hFF, -1, 0, got); ss_high(0);
      chk("trunc_rs", rs_cnt[0] - r0, 0); chk("trunc_ack", ack_cnt[0] - a0, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      chk("trunc_ferr", ferr_seen[0] - f0, 1);
`endif
      ss_low(0); xfer(0, 8, 32'h01, -1, 0, got); ss_high(0);
      chk("trunc_kept", got, 32'h77);

      // write coinciding with the frame-start load: old word goes out, new one stays pending
      wr(0, 32'h5A);
      a0 = ack_cnt[0];
      set_ss(0, 1'b0); mdl_start(0);
      tick(2);
      ssync_a = 1'b1; sdata_a = 8'h96; mdl_write(0, 32'h96);
      tick(1);
      ssync_a = 1'b0;
      tick(3);
      xfer(0, 8, 32'h33, -1, 0, got); xfer(0, 8, 32'h44, -1, 0, got2); ss_high(0);
      chk("coinc_old", got, 32'h5A); chk("coinc_new", got2, 32'h96);
      chk("coinc_ack", ack_cnt[0] - a0, 2);

      // reset at bit 3, then a clean frame
      wr(0, 32'h3F); ss_low(0); xfer(0, 3, 32'hAA, -1, 0, got);
      rst_n = 1'b0; mdl_reset();
      tick(1);
      chk("rst_mid_rd", rd_a, 8'h00); chk("rst_mid_rs", rs_a, 1'b0);
      chk("rst_mid_ack", ack_a, 1'b0); chk("rst_mid_miso", miso_a, 1'b0);
      ss_a = 1'b1; sck_a = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      ss_low(0); xfer(0, 8, 32'hC3, -1, 0, got); ss_high(0);
      chk("post_rst_rd", rd_a, 8'hC3); chk("post_rst_miso", got, 32'h0);

      // randomized windows on either instance
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 1);
         w = sel ? WB : WA;
         if ($urandom_range(0, 1) == 1) wr(sel, $urandom & wmask(sel));
         nw = $urandom_range(1, 3);
         ss_low(sel);
         for (int k = 0; k < nw; k++) begin
            wb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w - 1)) : -1;
            nb = (k == nw - 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, w - 1)) : w;
            xfer(sel, nb, $urandom & wmask(sel), wb, $urandom & wmask(sel), got);
         end
         ss_high(sel);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter IDLE_VALUE_for_Clk, default 0: SCK level while SS is high (CPOL).
REQ-002 SHALL have parameter DATA_VALID_at_FALLING, default 0: 1 samples MOSI on the SCK falling edge, 0 samples it on the rising edge; MISO shifts on the opposite edge.
REQ-003 SHALL have parameter TRAN_WIDTH, default 8: bits per frame, legal range 2..32, MSB first.
REQ-004 SHALL have parameter IDLE_VALUE_for_MISO, default 0: MISO level while SS is high.
REQ-005 SHALL have port c_clk_100m, input, 1 bit: the single system clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_SPI_Clk, input, 1 bit: SCK from the master, asynchronous to c_clk_100m.
REQ-008 SHALL have port i_SPI_SS, input, 1 bit: active-low slave select, asynchronous.
REQ-009 SHALL have port i_SPI_MOSI, input, 1 bit: master data, asynchronous.
REQ-010 SHALL have port o_SPI_MISO, output, 1 bit: slave data.
REQ-011 SHALL have port i_SPI_Send_Sync, input, 1 bit: one-cycle write strobe for the TX holding register.
REQ-012 SHALL have port i_SPI_Send_Data, input, TRAN_WIDTH bits: TX word captured on i_SPI_Send_Sync.
REQ-013 SHALL have port o_SPI_Send_Over_ack, output, 1 bit: one-cycle pulse when a written word has been fully shifted out.
REQ-014 SHALL have port o_SPI_Receive_Sync, output, 1 bit: one-cycle pulse when a complete word is received.
REQ-015 SHALL have port o_SPI_Receive_Data, output, TRAN_WIDTH bits: last complete RX word, held until the next one.

Function
REQ-016 SHALL pass i_SPI_Clk, i_SPI_SS and i_SPI_MOSI each through a 2-flop synchronizer, then use a third flop for edge detection; SCK period SHALL be at least 8 c_clk_100m cycles.
REQ-017 SHALL use states IDLE (SS high) and SHIFT (SS low); a synchronized SS falling edge moves IDLE->SHIFT, and a synchronized SS rising edge moves any state->IDLE.
REQ-018 On IDLE->SHIFT, SHALL load the TX shift register from the holding register if it is pending, otherwise with all zeros; bit counter is cleared; o_SPI_MISO SHALL drive the MSB by the 4th c_clk_100m edge after SS falls at the pin.
REQ-019 On each detected sample edge in SHIFT, SHALL shift the synchronized MOSI into the RX register LSB and increment the bit counter.
REQ-020 On each detected shift edge in SHIFT, SHALL advance o_SPI_MISO to the next bit; a shift edge before the first sample edge SHALL be ignored (CPHA-style leading edge).
REQ-021 On the TRAN_WIDTH-th sample edge, SHALL copy the RX register into o_SPI_Receive_Data, pulse o_SPI_Receive_Sync high for exactly 1 cycle, and clear the counter.
REQ-022 SHALL pulse o_SPI_Send_Over_ack for 1 cycle in that same cycle if the completed frame carried a pending word, and SHALL then clear pending.
REQ-023 With SS still low after a full word, SHALL reload TX per REQ-018 and continue back-to-back with no gap cycles.
REQ-024 On SS rising before TRAN_WIDTH bits, SHALL discard the partial word with no Receive_Sync or Send_Over_ack pulse, and the pending word SHALL stay pending.
REQ-025 i_SPI_Send_Sync SHALL overwrite the holding register and set pending at any time; when it coincides with a frame-start load, the load SHALL use the old value and the new word SHALL remain pending.
REQ-026 While in IDLE, o_SPI_MISO SHALL equal IDLE_VALUE_for_MISO.

Reset
REQ-027 While i_rst_n=0, SHALL force state IDLE, counter 0, pending 0, holding/TX/RX registers 0, o_SPI_Receive_Data 0, both pulse outputs 0, o_SPI_MISO=IDLE_VALUE_for_MISO, synchronizers to SCK=IDLE_VALUE_for_Clk, SS=1, MOSI=0.
REQ-028 Reset mid-frame SHALL abort the frame silently; after release, the next SS falling edge SHALL start a clean frame.

Configuration
REQ-029 With SPI_SLAVE_FRAME_ERR_EN defined, SHALL add output o_SPI_Frame_Err (1 bit, reset 0), pulsed 1 cycle on each truncated frame per REQ-024.
REQ-030 Without SPI_SLAVE_FRAME_ERR_EN, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 TRAN_WIDTH=8, defaults, written word 0xA5, master sends 0x3C -> master receives 0xA5, o_SPI_Receive_Data=0x3C with one Receive_Sync pulse and one Send_Over_ack pulse.
REQ-032 TRAN_WIDTH=24, DATA_VALID_at_FALLING=1, IDLE_VALUE_for_Clk=1, written 0x80A5A5, master sends 0x5A5A01 -> RX=0x5A5A01, master gets 0x80A5A5.
REQ-033 No write, 8-bit frame -> MISO shifts 0x00, Receive_Sync pulses, no Send_Over_ack.
REQ-034 Two words (0x11 then 0x22, each written before its frame starts) in one SS-low window -> two Receive_Sync pulses, master gets 0x11 then 0x22.
REQ-035 SS released after 5 bits -> no Receive_Sync, pending kept, o_SPI_Frame_Err pulses once when SPI_SLAVE_FRAME_ERR_EN is defined.
REQ-036 i_rst_n low at bit 3 -> all outputs match reset values; the following full frame with 0xC3 is received correctly.
